// File: rtl/naive_bus_pkg.sv
// rtl/naive_bus_pkg.sv - shared constants and helpers for naive_bus blocks
//
// Purpose: bus field widths, arbiter burst counter width and the burst
//          limit range check used by naive_bus_rr_arbiter.
// Ports:   none (package).
package naive_bus_pkg;

  localparam int NB_ADDR_W = 32;
  localparam int NB_DATA_W = 32;
  localparam int NB_BE_W   = NB_DATA_W / 8;

  // Width of the per-tenure grant counter in the round-robin arbiter.
  localparam int ARB_CNT_W = 8;

  // Clamps a requested burst limit into the legal range 1..255 so an
  // out-of-range parameter can never disable fairness or overflow cnt_q.
  function automatic logic [ARB_CNT_W-1:0] arb_burst_limit(input int max_burst);
    if (max_burst < 1) begin
      return ARB_CNT_W'(1);
    end else if (max_burst > 255) begin
      return ARB_CNT_W'(255);
    end
    return ARB_CNT_W'(max_burst);
  endfunction

endpackage

// File: rtl/naive_bus_if.sv
// rtl/naive_bus_if.sv - naive_bus request/grant bus interface
//
// Purpose: one naive_bus link; read data returns one cycle after rd_gnt.
// Signals: rd_req/rd_addr -> rd_gnt, rd_data (next cycle);
//          wr_req/wr_addr/wr_data/wr_be -> wr_gnt.
// Modports: master drives requests, slave drives grants and read data.
interface naive_bus;
  import naive_bus_pkg::*;

  logic                 rd_req;
  logic                 rd_gnt;
  logic [NB_ADDR_W-1:0] rd_addr;
  logic [NB_DATA_W-1:0] rd_data;
  logic                 wr_req;
  logic                 wr_gnt;
  logic [NB_ADDR_W-1:0] wr_addr;
  logic [NB_DATA_W-1:0] wr_data;
  logic [NB_BE_W-1:0]   wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating find-first requester picker
//
// Purpose: scans last+1, last+2, ... modulo N and returns the first set
//          request bit; last itself is scanned last.
// Ports:   req   in  N          request vector
//          last  in  $clog2(N)  index that was served last
//          found out 1          any request set
//          next  out $clog2(N)  chosen index (last when none found)
module rr_priority_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 found,
  output logic [$clog2(N)-1:0] next
);

  localparam int W = $clog2(N);

  int idx;

  always_comb begin
    found = 1'b0;
    next  = last;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        next  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/naive_bus_rr_arbiter.sv
// rtl/naive_bus_rr_arbiter.sv - round-robin arbiter sharing one naive_bus slave
//
// Purpose: N_MASTER upstream masters share one downstream slave; the owner
//          keeps the bus for up to MAX_BURST grants while others wait, then
//          ownership rotates. Zero added latency on request/grant.
// Ports:   clk      in   clock
//          rst_n    in   asynchronous active-low reset
//          masters  naive_bus.slave [N_MASTER]  upstream ports
//          slave    naive_bus.master            downstream port
//          o_owner  out  currently selected master index
//          o_busy   out  any master requesting this cycle
module naive_bus_rr_arbiter
  import naive_bus_pkg::*;
#(
  parameter int N_MASTER  = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  naive_bus.slave                     masters [N_MASTER],
  naive_bus.master                    slave,
  output logic [$clog2(N_MASTER)-1:0] o_owner,
  output logic                        o_busy
);

  localparam int IDX_W = $clog2(N_MASTER);
  localparam logic [ARB_CNT_W-1:0] BURST_LIM = arb_burst_limit(MAX_BURST);

  logic [N_MASTER-1:0]  m_rd_req;
  logic [N_MASTER-1:0]  m_wr_req;
  logic [NB_ADDR_W-1:0] m_rd_addr [N_MASTER];
  logic [NB_ADDR_W-1:0] m_wr_addr [N_MASTER];
  logic [NB_DATA_W-1:0] m_wr_data [N_MASTER];
  logic [NB_BE_W-1:0]   m_wr_be   [N_MASTER];

  logic [N_MASTER-1:0]  req;
  logic [N_MASTER-1:0]  others;
  logic                 keep;
  logic                 found;
  logic [IDX_W-1:0]     next_idx;
  logic [IDX_W-1:0]     sel;
  logic                 gnt;

  logic [IDX_W-1:0]     owner_q;
  logic [ARB_CNT_W-1:0] cnt_q;
  logic                 rd_pend_q;
  logic [IDX_W-1:0]     rd_idx_q;

  // Flatten the interface array so the muxes can use a run-time index.
  for (genvar g = 0; g < N_MASTER; g++) begin : g_master
    assign m_rd_req[g]  = masters[g].rd_req;
    assign m_wr_req[g]  = masters[g].wr_req;
    assign m_rd_addr[g] = masters[g].rd_addr;
    assign m_wr_addr[g] = masters[g].wr_addr;
    assign m_wr_data[g] = masters[g].wr_data;
    assign m_wr_be[g]   = masters[g].wr_be;

    assign masters[g].rd_gnt  = rst_n & slave.rd_gnt & (sel == IDX_W'(g));
    assign masters[g].wr_gnt  = rst_n & slave.wr_gnt & (sel == IDX_W'(g));
    // Return path follows the index registered at grant time, not the
    // current selection, so a switch right after a read cannot misroute.
    assign masters[g].rd_data = (rd_pend_q && (rd_idx_q == IDX_W'(g)))
                              ? slave.rd_data : '0;
  end

  assign req = m_rd_req | m_wr_req;

  always_comb begin
    others          = req;
    others[owner_q] = 1'b0;
  end

  // cnt_q == 0 means no tenure is running (after reset), so the reset
  // owner has no claim and the scan starting after it picks master 0.
  assign keep = req[owner_q] && (cnt_q != '0)
             && ((cnt_q < BURST_LIM) || (others == '0));

  rr_priority_pick #(
    .N (N_MASTER)
  ) u_pick (
    .req   (req),
    .last  (owner_q),
    .found (found),
    .next  (next_idx)
  );

  always_comb begin
    sel = owner_q;
    if (!keep && found) begin
      sel = next_idx;
    end
  end

  assign slave.rd_req  = rst_n & m_rd_req[sel];
  assign slave.wr_req  = rst_n & m_wr_req[sel];
  assign slave.rd_addr = m_rd_addr[sel];
  assign slave.wr_addr = m_wr_addr[sel];
  assign slave.wr_data = m_wr_data[sel];
  assign slave.wr_be   = m_wr_be[sel];

  assign o_owner = sel;
  assign o_busy  = rst_n & (|req);

  // A read and a write granted together count as one transaction.
  assign gnt = slave.rd_gnt | slave.wr_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= IDX_W'(N_MASTER - 1);
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      if (gnt) begin
        if (sel == owner_q) begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          owner_q <= sel;
          cnt_q   <= ARB_CNT_W'(1);
        end
      end
      rd_pend_q <= slave.rd_gnt;
      if (slave.rd_gnt) begin
        rd_idx_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// tb/tb_naive_bus_rr_arbiter.sv - self-checking bench for naive_bus_rr_arbiter
module tb_naive_bus_rr_arbiter;

  localparam logic [31:0] KEY = 32'hDA7A_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  naive_bus m_if [3] ();
  naive_bus s_if ();

  logic [2:0]  m_rd_req = '0;
  logic [2:0]  m_wr_req = '0;
  logic [31:0] m_rd_addr [3];
  wire  [2:0]  m_rd_gnt;
  wire  [2:0]  m_wr_gnt;
  wire  [31:0] m_rd_data [3];
  logic        gnt_en = 1'b0;
  logic [31:0] s_rd_data = '0;
  logic [1:0]  o_owner;
  logic        o_busy;

  for (genvar g = 0; g < 3; g++) begin : g_m
    assign m_if[g].rd_req  = m_rd_req[g];
    assign m_if[g].wr_req  = m_wr_req[g];
    assign m_if[g].rd_addr = m_rd_addr[g];
    assign m_if[g].wr_addr = 32'h0000_1000 * (g + 1);
    assign m_if[g].wr_data = 32'hC0DE_0000 | g;
    assign m_if[g].wr_be   = 4'hF;
    assign m_rd_gnt[g]     = m_if[g].rd_gnt;
    assign m_wr_gnt[g]     = m_if[g].wr_gnt;
    assign m_rd_data[g]    = m_if[g].rd_data;
  end

  // Shared slave: grants whatever is requested when enabled, returns
  // addr ^ KEY one cycle after a read grant.
  assign s_if.rd_gnt  = gnt_en & s_if.rd_req;
  assign s_if.wr_gnt  = gnt_en & s_if.wr_req;
  assign s_if.rd_data = s_rd_data;
  always @(posedge clk) s_rd_data <= s_if.rd_gnt ? (s_if.rd_addr ^ KEY) : 32'h0;

  naive_bus_rr_arbiter #(
    .N_MASTER  (3),
    .MAX_BURST (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .masters (m_if),
    .slave   (s_if),
    .o_owner (o_owner),
    .o_busy  (o_busy)
  );

  typedef struct {
    logic       do_rst;
    logic [2:0] rd;
    logic [2:0] wr;
    logic       gen;
    logic [1:0] exp_owner;
    logic [2:0] exp_rd_gnt;
    logic [2:0] exp_wr_gnt;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    m_rd_req = '0;
    m_wr_req = '0;
    gnt_en   = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_rd_addr[i] = '0;

    // Burst rotation: all write continuously, grants 0x4, 1x4, 2x4, 0x4.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] own;
      own = 2'((i / 4) % 3);
      vecs.push_back('{(i == 0), 3'b000, 3'b111, 1'b1, own, 3'b000, 3'b001 << own, 1'b1});
    end
    // Slave stalls 5 cycles: nothing moves, then master 0 gets a full burst.
    for (int i = 0; i < 5; i++)
      vecs.push_back('{(i == 0), 3'b000, 3'b011, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{1'b0, 3'b000, 3'b011, 1'b1, (i < 4) ? 2'd0 : 2'd1, 3'b000,
                       (i < 4) ? 3'b001 : 3'b010, 1'b1});
    // Idle: selection stays on the last owner, nothing forwarded.
    vecs.push_back('{1'b0, 3'b000, 3'b000, 1'b1, 2'd1, 3'b000, 3'b000, 1'b0});

    // Reset state
    @(negedge clk);
    #2;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_owner", 32'(o_owner), 32'd2);
    check("rst_rd_req", 32'(s_if.rd_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sequences
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].do_rst) do_reset();
      m_rd_req = vecs[v].rd;
      m_wr_req = vecs[v].wr;
      gnt_en   = vecs[v].gen;
      #2;
      check($sformatf("vec%0d_owner", v), 32'(o_owner), 32'(vecs[v].exp_owner));
      check($sformatf("vec%0d_rd_gnt", v), 32'(m_rd_gnt), 32'(vecs[v].exp_rd_gnt));
      check($sformatf("vec%0d_wr_gnt", v), 32'(m_wr_gnt), 32'(vecs[v].exp_wr_gnt));
      check($sformatf("vec%0d_busy", v), 32'(o_busy), 32'(vecs[v].exp_busy));
      if (vecs[v].exp_wr_gnt != 3'b000)
        check($sformatf("vec%0d_wdata", v), s_if.wr_data, 32'hC0DE_0000 | 32'(vecs[v].exp_owner));
      @(negedge clk);
    end

    // Master 1 alone: 3 reads, data one cycle after each grant
    do_reset();
    gnt_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_rd_req     = 3'b010;
      m_rd_addr[1] = 32'h0002_0000 + 32'(4 * k);
      #2;
      check("t1_rd_gnt", 32'(m_rd_gnt), 32'b010);
      check("t1_owner", 32'(o_owner), 32'd1);
      check("t1_slave_addr", s_if.rd_addr, 32'h0002_0000 + 32'(4 * k));
      if (k > 0) begin
        check("t1_m1_data", m_rd_data[1], (32'h0002_0000 + 32'(4 * (k - 1))) ^ KEY);
        check("t1_m0_data", m_rd_data[0], 32'h0);
        check("t1_m2_data", m_rd_data[2], 32'h0);
      end
      @(negedge clk);
    end
    m_rd_req = 3'b000;
    #2;
    check("t1_last_data", m_rd_data[1], 32'h0002_0008 ^ KEY);
    check("t1_idle_gnt", 32'(m_rd_gnt), 32'd0);
    @(negedge clk);
    #2;
    check("t1_data_cleared", m_rd_data[1], 32'h0);
    @(negedge clk);

    // Read by 0 then immediate grant to 2: data stays with its requester
    do_reset();
    gnt_en = 1'b1;
    m_rd_req = 3'b001;
    m_rd_addr[0] = 32'h0000_0100;
    #2;
    check("t3_gnt0", 32'(m_rd_gnt), 32'b001);
    @(negedge clk);
    m_rd_req = 3'b100;
    m_rd_addr[2] = 32'h0000_0300;
    #2;
    check("t3_gnt2", 32'(m_rd_gnt), 32'b100);
    check("t3_owner2", 32'(o_owner), 32'd2);
    check("t3_m0_data", m_rd_data[0], 32'h0000_0100 ^ KEY);
    check("t3_m2_nodata", m_rd_data[2], 32'h0);
    @(negedge clk);
    m_rd_req = 3'b000;
    #2;
    check("t3_m2_data", m_rd_data[2], 32'h0000_0300 ^ KEY);
    check("t3_m0_nodata", m_rd_data[0], 32'h0);
    @(negedge clk);

    // Simultaneous rd+wr grant from master 2 counts once
    do_reset();
    gnt_en = 1'b1;
    m_rd_req = 3'b100;
    m_wr_req = 3'b100;
    m_rd_addr[2] = 32'h0000_0500;
    #2;
    check("t5_rd_gnt", 32'(m_rd_gnt), 32'b100);
    check("t5_wr_gnt", 32'(m_wr_gnt), 32'b100);
    @(negedge clk);
    m_rd_req = 3'b000;
    m_wr_req = 3'b101;
    for (int j = 0; j < 4; j++) begin
      #2;
      check($sformatf("t5_burst%0d", j), 32'(m_wr_gnt), (j < 3) ? 32'b100 : 32'b001);
      if (j == 0) check("t5_m2_data", m_rd_data[2], 32'h0000_0500 ^ KEY);
      @(negedge clk);
    end

    // Reset one cycle after a read grant drops the return
    do_reset();
    gnt_en = 1'b1;
    m_rd_req = 3'b010;
    m_rd_addr[1] = 32'h0000_4000;
    #2;
    check("t6_gnt1", 32'(m_rd_gnt), 32'b010);
    @(negedge clk);
    rst_n = 1'b0;
    m_rd_req = 3'b111;
    m_wr_req = 3'b111;
    #2;
    check("t6_m1_data", m_rd_data[1], 32'h0);
    check("t6_rst_rd_gnt", 32'(m_rd_gnt), 32'd0);
    check("t6_rst_wr_gnt", 32'(m_wr_gnt), 32'd0);
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    check("t6_rst_slave_req", 32'({s_if.rd_req, s_if.wr_req}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("t6_first_rd", 32'(m_rd_gnt), 32'b001);
    check("t6_first_wr", 32'(m_wr_gnt), 32'b001);
    check("t6_owner", 32'(o_owner), 32'd0);
    check("t6_no_data", m_rd_data[1], 32'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/naive_bus_rr_arbiter.md
# naive_bus_rr_arbiter

- Shares one `naive_bus` slave port between `N_MASTER` `naive_bus` masters.
- Arbitration is round-robin with a bounded burst hold, so a busy master cannot starve the others.
- It is the fair alternative to the fixed-priority arbitration in `naive_bus_router`. It sits in front of a contended slave, e.g. a video RAM shared by the core data master and a future DMA/blitter.
- Arbitration adds zero cycles to request/grant and preserves the one-cycle read-data return of the bus.

## Interface
Parameters:
- `N_MASTER`, 3: number of upstream masters, 2..8.
- `MAX_BURST`, 4: maximum consecutive granted transactions per owner while others wait, 1..255.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `masters`  naive_bus.slave  [N_MASTER]: upstream ports (rd_req, rd_gnt, rd_addr, rd_data, wr_req, wr_gnt, wr_addr, wr_data, wr_be).
- `slave`  naive_bus.master  1: downstream port to the shared slave.
- `o_owner`  out  $clog2(N_MASTER): index currently selected.
- `o_busy`  out  1: any master requesting this cycle.

## Operation
Request and ownership:
- `req[i] = masters[i].rd_req | masters[i].wr_req`.
- Registered state: `owner_q` (last granted index), `cnt_q` (transactions granted to `owner_q` in its current tenure, 8 bit), `rd_pend_q`, `rd_idx_q`.

Selection (combinational, every cycle):
- If `req[owner_q]` and (`cnt_q < MAX_BURST` or no other master requesting): select `owner_q`.
- Otherwise select the first requester scanning `owner_q+1, owner_q+2, …` modulo `N_MASTER`.
- No requesters: select `owner_q`; all forwarded reqs are 0.

Forwarding:
- The selected master's rd_req/rd_addr/wr_req/wr_addr/wr_data/wr_be drive `slave`.
- `slave.rd_gnt`/`wr_gnt` return only to the selected master.
- Non-selected masters see gnt = 0.

State update on each `slave.rd_gnt | slave.wr_gnt`:
- If selected == `owner_q`: `cnt_q` ← saturating `cnt_q+1`.
- Else: `owner_q` ← selected, `cnt_q` ← 1.
- rd_gnt and wr_gnt in the same cycle count once.
- A cycle with no gnt leaves the state unchanged. A waiting master therefore keeps its position, and the owner cannot be pre-empted mid-handshake.

Read return:
- On `slave.rd_gnt`: `rd_pend_q` ← 1, `rd_idx_q` ← selected. Otherwise `rd_pend_q` ← 0.
- `masters[rd_idx_q].rd_data` = `slave.rd_data` while `rd_pend_q`. All other masters' rd_data = 0, and all rd_data = 0 when `rd_pend_q` = 0.
- A master switch in the cycle right after a read grant does not misroute data, because routing uses `rd_idx_q`, not the current selection.

Reset (`rst_n` low, asynchronous):
- `owner_q` = N_MASTER-1, so master 0 wins first. `cnt_q` = 0, `rd_pend_q` = 0.
- While `rst_n` is low, slave rd_req/wr_req are forced to 0, all master gnt to 0, all master rd_data to 0, and `o_busy` to 0.
- Reset mid-read drops the pending return. After release, arbitration restarts from master 0.

## Timing
- Request to slave req: combinational, 0 cycles. Slave gnt to master gnt: combinational.
- Read data reaches the master exactly 1 cycle after its rd_gnt, unchanged from a direct connection.
- Worst-case wait for a continuously requesting master: (N_MASTER-1)·MAX_BURST granted transactions.
- Owner switch takes effect in the cycle after the gnt that ended the tenure.
- Back-to-back grants to different masters in consecutive cycles are legal.
- `o_owner` = selected index, combinational.

## Structure
- `naive_bus_pkg` holds `ARB_CNT_W` = 8 and the `MAX_BURST` range check. The `naive_bus` interface is reused unchanged.
- Sub-module `rr_priority_pick #(N)`: inputs req vector and last index; outputs found flag and next index (rotate + find-first). It is purely combinational and reusable by a future DMA channel scheduler.
- Registers and forwarding muxes live in the top module.

## Test plan
1. Master 1 alone issues 3 reads to 0x0002_0000..0x0002_0008 → each granted the same cycle; data of word k appears on master 1 one cycle after grant k; masters 0 and 2 see gnt = 0 and rd_data = 0.
2. Masters 0, 1, 2 all request writes continuously, MAX_BURST = 4 → grant order 0×4, 1×4, 2×4, 0×4; `o_owner` changes in the cycle after each 4th grant.
3. Master 0 reads at cycle t; master 2 is granted at t+1 → rd_data at t+1 goes to master 0 only, and master 2 still gets its own data at t+2.
4. Slave holds gnt low for 5 cycles while masters 0 and 1 request → `owner_q` and `cnt_q` unchanged; master 0 is granted when gnt rises.
5. Simultaneous rd_req and wr_req from master 2; slave grants both in one cycle → `cnt_q` increments by 1 only.
6. Assert `rst_n` low one cycle after a read grant → no rd_data delivered. After release with all three masters requesting, master 0 is granted first.
